ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 256 x 32 synchronous RAM (`cen`/`wen`/`addr`/`din`/`dout`) between two requesters. It takes read and write requests from requester 0 and requester 1, picks a winner each cycle, and drives the RAM control and data inputs from registers. Read data returns to whichever requester issued the read. It sits between the RAM and the datapath engines that store operands and results.

---
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bundle of the requester-side and RAM-side signals of ram_arbiter.
// The slave modport is the arbiter's view of the bundle; the master modport is the environment's view.
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m1_req;
    logic          m0_wr;
    logic          m1_wr;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m0_gnt;
    logic          m1_gnt;
    logic          m0_rvalid;
    logic          m1_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_cen;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_dout,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
        output ram_cen, ram_wen, ram_addr, ram_din
    );

    modport master (
        output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_dout,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
        input  ram_cen, ram_wen, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// Tie-break is round-robin by default; define RAM_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    logic [1:0]    w_req;
    logic [1:0]    w_wr;
    logic [AW-1:0] w_addr  [2];
    logic [DW-1:0] w_wdata [2];
    logic [1:0]    w_eff;
    logic          w_any;
    logic          w_win;

    logic [1:0]    r_gnt;
    logic [1:0]    r_rvalid;
    logic          r_rd_pend;
    logic          r_rd_owner;
    logic          r_cen;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;

    assign w_req      = {bus.m1_req, bus.m0_req};
    assign w_wr       = {bus.m1_wr, bus.m0_wr};
    assign w_addr[0]  = bus.m0_addr;
    assign w_addr[1]  = bus.m1_addr;
    assign w_wdata[0] = bus.m0_wdata;
    assign w_wdata[1] = bus.m1_wdata;

    // A request whose grant is showing this cycle is the one already accepted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_eff
            assign w_eff[gi] = w_req[gi] & ~r_gnt[gi];
        end
    endgenerate

    assign w_any = |w_eff;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = 1'b0;
        if (w_eff == 2'b10) begin
            w_win = 1'b1;
        end
    end
`else
    logic r_last;

    always_comb begin
        w_win = 1'b0;
        if (w_eff == 2'b10) begin
            w_win = 1'b1;
        end else if (w_eff == 2'b11) begin
            w_win = ~r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_any) begin
            r_last <= w_win;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_cen      <= 1'b0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
        end else begin
            r_cen      <= w_any;
            r_gnt      <= '0;
            r_rd_pend  <= w_any & ~w_wr[w_win];
            r_rd_owner <= w_win;
            r_rvalid   <= '0;
            if (w_any) begin
                r_gnt[w_win] <= 1'b1;
                r_wen        <= w_wr[w_win];
                r_addr       <= w_addr[w_win];
                r_din        <= w_wdata[w_win];
            end
            // The RAM read happens during the grant cycle, so data is on ram_dout one cycle later.
            if (r_rd_pend) begin
                r_rvalid[r_rd_owner] <= 1'b1;
            end
        end
    end

    assign bus.m0_gnt    = r_gnt[0];
    assign bus.m1_gnt    = r_gnt[1];
    assign bus.m0_rvalid = r_rvalid[0];
    assign bus.m1_rvalid = r_rvalid[1];
    assign bus.rdata     = bus.ram_dout;
    assign bus.ram_cen   = r_cen;
    assign bus.ram_wen   = r_wen;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_din   = r_din;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, sweep, mid-operation reset and a randomized run
// checked against a transaction-level model; honours RAM_ARB_FIXED_PRIO_EN.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(8), .DW(32)) bus ();

    ram_arbiter #(.AW(8), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural single-port RAM with registered read.
    logic [31:0] mem [256];
    logic [31:0] ram_dout_r;
    always @(posedge clk) begin
        if (bus.ram_cen) begin
            if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
            else             ram_dout_r <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_dout = ram_dout_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int who, input bit req, input bit wr,
                           input logic [7:0] a, input logic [31:0] d);
        if (who == 0) begin
            bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    function automatic logic gnt_of(input int who);
        return (who == 0) ? bus.m0_gnt : bus.m1_gnt;
    endfunction

    function automatic logic rv_of(input int who);
        return (who == 0) ? bus.m0_rvalid : bus.m1_rvalid;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, 0, 0, 8'h00, 32'h0);
        set_req(1, 0, 0, 8'h00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        chk("rst_cen_wen", {30'd0, bus.ram_cen, bus.ram_wen}, 32'd0);
        chk("rst_addr", {24'd0, bus.ram_addr}, 32'd0);
        chk("rst_din", bus.ram_din, 32'd0);
        reset = 1'b0;
    endtask

    // One complete access by one requester, with a bounded wait for the grant.
    task automatic access(input int who, input bit wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        bit got = 0;
        set_req(who, 1, wr, a, d);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (gnt_of(who)) begin
                got = 1;
                break;
            end
        end
        set_req(who, 0, 0, 8'h00, 32'h0);
        chk("acc_gnt", {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clk); #1;
            chk("acc_rvalid", {31'd0, rv_of(who)}, {31'd0, ~wr});
            chk("acc_other_rvalid", {31'd0, rv_of(1 - who)}, 32'd0);
            if (!wr) chk("acc_rdata", bus.rdata, exp_rd);
        end
        $display("access m%0d %s addr=%h data=%h", who, wr ? "WR" : "RD", a, wr ? d : bus.rdata);
    endtask

    typedef struct {
        bit          r0, w0;
        logic [7:0]  a0;
        logic [31:0] d0;
        bit          r1, w1;
        logic [7:0]  a1;
        logic [31:0] d1;
        bit          g0, g1, v0, v1, cen, wen;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [13];

    // Transaction-level model state for the randomized run.
    logic [31:0] mmem [256];
    bit          eg  [4][2];
    bit          erv [4][2];
    bit          ecen[4];
    logic [31:0] erd [4];
    bit          pend [2];
    bit          pwr  [2];
    logic [7:0]  paddr[2];
    logic [31:0] pdat [2];
    int          m_last;

    initial begin
        logic [31:0] dummy;
        dummy = 32'h0;
        do_reset();

        // Sweep: m0 writes data = address everywhere, m1 reads it all back.
        for (int k = 0; k < 256; k++) access(0, 1, k[7:0], k, dummy);
        for (int k = 0; k < 256; k++) access(1, 0, k[7:0], 32'h0, k);

        // Directed table; outputs listed are those visible in the same cycle as the inputs.
        tbl[0]  = '{1,1,8'h05,32'h11, 0,0,8'h00,32'h0,  0,0,0,0, 0,0, 8'h00, 32'h00, 32'h0};
        tbl[1]  = '{1,1,8'h05,32'h11, 0,0,8'h00,32'h0,  1,0,0,0, 1,1, 8'h05, 32'h11, 32'h0};
        tbl[2]  = '{0,0,8'h00,32'h0,  1,0,8'h05,32'h0,  0,0,0,0, 0,1, 8'h05, 32'h11, 32'h0};
        tbl[3]  = '{0,0,8'h00,32'h0,  1,0,8'h05,32'h0,  0,1,0,0, 1,0, 8'h05, 32'h00, 32'h0};
        tbl[4]  = '{0,0,8'h00,32'h0,  0,0,8'h00,32'h0,  0,0,0,1, 0,0, 8'h05, 32'h00, 32'h11};
        tbl[5]  = '{0,0,8'h00,32'h0,  0,0,8'h00,32'h0,  0,0,0,0, 0,0, 8'h05, 32'h00, 32'h0};
        tbl[6]  = '{1,0,8'h01,32'h0,  1,0,8'h02,32'h0,  0,0,0,0, 0,0, 8'h05, 32'h00, 32'h0};
        tbl[7]  = '{1,0,8'h01,32'h0,  1,0,8'h02,32'h0,  1,0,0,0, 1,0, 8'h01, 32'h00, 32'h0};
        tbl[8]  = '{1,0,8'h01,32'h0,  1,0,8'h02,32'h0,  0,1,1,0, 1,0, 8'h02, 32'h00, 32'h1};
        tbl[9]  = '{1,0,8'h01,32'h0,  1,0,8'h02,32'h0,  1,0,0,1, 1,0, 8'h01, 32'h00, 32'h2};
        tbl[10] = '{0,0,8'h00,32'h0,  0,0,8'h00,32'h0,  0,1,1,0, 1,0, 8'h02, 32'h00, 32'h1};
        tbl[11] = '{0,0,8'h00,32'h0,  0,0,8'h00,32'h0,  0,0,0,1, 0,0, 8'h02, 32'h00, 32'h2};
        tbl[12] = '{0,0,8'h00,32'h0,  0,0,8'h00,32'h0,  0,0,0,0, 0,0, 8'h02, 32'h00, 32'h0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            set_req(0, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
            set_req(1, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            chk("tbl_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, tbl[i].g1, tbl[i].g0});
            chk("tbl_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, {30'd0, tbl[i].v1, tbl[i].v0});
            chk("tbl_cen_wen", {30'd0, bus.ram_cen, bus.ram_wen}, {30'd0, tbl[i].cen, tbl[i].wen});
            chk("tbl_addr", {24'd0, bus.ram_addr}, {24'd0, tbl[i].addr});
            chk("tbl_din", bus.ram_din, tbl[i].din);
            if (tbl[i].v0 || tbl[i].v1) chk("tbl_rdata", bus.rdata, tbl[i].rd);
            $display("vec %0d gnt=%b%b rvalid=%b%b cen=%b addr=%h rdata=%h", i, bus.m1_gnt,
                     bus.m0_gnt, bus.m1_rvalid, bus.m0_rvalid, bus.ram_cen, bus.ram_addr, bus.rdata);
        end

        // Reset in the grant cycle of a read: access cancelled, rvalid dropped, last restored.
        @(posedge clk); #1;
        set_req(0, 1, 0, 8'h03, 32'h0);
        @(posedge clk); #1;
        chk("mid_gnt0", {31'd0, bus.m0_gnt}, 32'd1);
        set_req(0, 0, 0, 8'h00, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_cen", {31'd0, bus.ram_cen}, 32'd0);
        chk("mid_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        reset = 1'b0;
        set_req(0, 1, 0, 8'h04, 32'h0);
        set_req(1, 1, 0, 8'h06, 32'h0);
        @(posedge clk); #1;
        chk("mid_tie_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd1);
        set_req(0, 0, 0, 8'h00, 32'h0);
        @(posedge clk); #1;
        chk("mid_gnt1", {31'd0, bus.m1_gnt}, 32'd1);
        chk("mid_rv0", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("mid_rd0", bus.rdata, 32'd4);
        set_req(1, 0, 0, 8'h00, 32'h0);
        @(posedge clk); #1;
        chk("mid_rv1", {31'd0, bus.m1_rvalid}, 32'd1);
        chk("mid_rd1", bus.rdata, 32'd6);
        $display("mid-reset sequence done");

        // Randomized run against the transaction-level model.
        do_reset();
        for (int k = 0; k < 256; k++) mmem[k] = k;
        mmem[5] = 32'h11;
        for (int s = 0; s < 4; s++) begin
            eg[s][0] = 0; eg[s][1] = 0; erv[s][0] = 0; erv[s][1] = 0; ecen[s] = 0; erd[s] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; pwr[i] = 0; paddr[i] = 0; pdat[i] = 0;
        end
        m_last = 1;
        for (int t = 0; t < 3000; t++) begin
            int  s, n, m, win;
            bit  eff [2];
            s = t % 4;
            n = (t + 1) % 4;
            m = (t + 2) % 4;
            @(posedge clk); #1;
            chk("rnd_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, eg[s][1], eg[s][0]});
            chk("rnd_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, {30'd0, erv[s][1], erv[s][0]});
            chk("rnd_cen", {31'd0, bus.ram_cen}, {31'd0, ecen[s]});
            if (erv[s][0] || erv[s][1]) chk("rnd_rdata", bus.rdata, erd[s]);

            for (int i = 0; i < 2; i++) begin
                if (pend[i] && eg[s][i]) pend[i] = 0;
                else if (pend[i] && $urandom_range(15) == 0) pend[i] = 0;
                if (!pend[i] && $urandom_range(2) != 0) begin
                    pend[i]  = 1;
                    pwr[i]   = $urandom_range(1) == 1;
                    paddr[i] = ($urandom_range(9) == 0) ? 8'hFF : 8'($urandom_range(7));
                    pdat[i]  = $urandom;
                end
                set_req(i, pend[i], pwr[i], paddr[i], pdat[i]);
            end

            for (int i = 0; i < 2; i++) eff[i] = pend[i] && !eg[s][i];
            win = -1;
            if (eff[0] && eff[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = 1 - m_last;
`endif
            end else if (eff[0]) win = 0;
            else if (eff[1])     win = 1;
            if (win >= 0) begin
                m_last      = win;
                eg[n][win]  = 1;
                ecen[n]     = 1;
                if (pwr[win]) mmem[paddr[win]] = pdat[win];
                else begin
                    erv[m][win] = 1;
                    erd[m]      = mmem[paddr[win]];
                end
            end
            eg[s][0] = 0; eg[s][1] = 0; erv[s][0] = 0; erv[s][1] = 0; ecen[s] = 0;
        end
        $display("random run done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
